// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the sequential multiplier and divider.
// Also intended for the planned adder.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam int          FP_MANT_W  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_t;

  // Denormals are flushed, so any zero exponent classifies as zero.
  function automatic fp_class_t fp_classify(input fp32_t x);
    if (x.exp == FP_EXP_MAX) return (x.frac != 23'd0) ? CLS_NAN : CLS_INF;
    if (x.exp == 8'd0)       return CLS_ZERO;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_special_detect.sv
// Operand classification and special-case override word for fp_mul_seq.
// Purely combinational; evaluated on the latched operands.
module fp_special_detect
  import fp32_pkg::*;
(
  input  fp32_t       a,
  input  fp32_t       b,
  output logic [31:0] override_word,
  output logic        override_valid
);

  fp_class_t cls_a;
  fp_class_t cls_b;
  logic      sign;

  assign cls_a = fp_classify(a);
  assign cls_b = fp_classify(b);
  assign sign  = a.sign ^ b.sign;

  // Priority: NaN, inf x zero, inf x finite, zero/denormal.
  always_comb begin
    override_word  = 32'd0;
    override_valid = 1'b0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      override_word  = FP_QNAN;
      override_valid = 1'b1;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      override_word  = FP_QNAN;
      override_valid = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      override_word  = {sign, FP_EXP_MAX, 23'd0};
      override_valid = 1'b1;
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      override_word  = {sign, 31'd0};
      override_valid = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier: 24-cycle radix-2 shift-add, truncating
// normalize, IEEE special cases, fixed 26-cycle start-to-enable latency.
module fp_mul_seq
  import fp32_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        enable,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MULT = MULT;
  localparam logic [1:0] S_NORM = NORM;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]  state;
  fp32_t       a_r;
  fp32_t       b_r;
  logic        sign_r;
  logic [47:0] prod;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [4:0]  cnt;

  logic [31:0]       override_word;
  logic              override_valid;
  logic signed [9:0] exp_norm;
  logic [22:0]       frac_norm;
  logic [31:0]       final_word;
  logic              final_ovf;
  logic              final_unf;

  fp_special_detect u_special (
    .a              (a_r),
    .b              (b_r),
    .override_word  (override_word),
    .override_valid (override_valid)
  );

  // Product of two [1,2) significands lies in [1,4); bit 47 picks the shift.
  always_comb begin
    exp_norm  = 10'({2'b00, a_r.exp}) + 10'({2'b00, b_r.exp})
              - 10'(FP_BIAS) + 10'(prod[47]);
    frac_norm = prod[47] ? prod[46:24] : prod[45:23];
    final_ovf = 1'b0;
    final_unf = 1'b0;
    if (override_valid) begin
      final_word = override_word;
    end else if (exp_norm >= 10'sd255) begin
      final_word = {sign_r, FP_EXP_MAX, 23'd0};
      final_ovf  = 1'b1;
    end else if (exp_norm <= 10'sd0) begin
      final_word = {sign_r, 31'd0};
      final_unf  = 1'b1;
    end else begin
      final_word = {sign_r, exp_norm[7:0], frac_norm};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= A;
            b_r    <= B;
            sign_r <= A[31] ^ B[31];
            mcand  <= {24'd0, 1'b1, A[22:0]};
            mplier <= {1'b1, B[22:0]};
            prod   <= '0;
            cnt    <= '0;
            state  <= S_MULT;
          end
        end
        S_MULT: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(FP_MANT_W - 1)) state <= S_NORM;
        end
        S_NORM: begin
          result    <= final_word;
          overflow  <= final_ovf;
          underflow <= final_unf;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign enable = (state == S_DONE);
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed cases, handshake, mid-op
// reset and randomized operands against a plain-arithmetic reference model.
module tb_fp_mul_seq;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        enable;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .A         (A),
    .B         (B),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .enable    (enable),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // IEEE binary32 product with flush-to-zero inputs and truncation.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output logic u);
    int          ea, eb, e;
    logic        an, bn, ai, bi, az, bz, s;
    logic [63:0] p;
    logic [22:0] f;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    s  = a[31] ^ b[31];
    o  = 1'b0;
    u  = 1'b0;
    if (an || bn)                    r = 32'h7FC00000;
    else if ((ai && bz) || (az && bi)) r = 32'h7FC00000;
    else if (ai || bi)               r = {s, 8'hFF, 23'd0};
    else if (az || bz)               r = {s, 31'd0};
    else begin
      p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin
        e++;
        f = p[46:24];
      end else begin
        f = p[45:23];
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        o = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        u = 1'b1;
      end else begin
        r = {s, 8'(e), f};
      end
    end
  endfunction

  // Issue one operation from IDLE and check latency, busy, hold and outputs.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input logic eu,
                        input string tag);
    int          lat;
    logic [31:0] prev;
    logic        held;
    prev = result;
    held = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 1;
    while (!enable && lat < 40) begin
      if (result !== prev || busy !== 1'b1) held = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd26);
    check({tag, " busy/hold"}, {31'd0, held}, 32'd1);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, {30'd0, overflow, underflow}, {30'd0, eo, eu});
    check({tag, " busy@done"}, {31'd0, busy}, 32'd1);
    @(posedge CLK); #1;
    check({tag, " idle"}, {30'd0, busy, enable}, 32'd0);
  endtask

  task automatic run_ref(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r;
    logic        o, u;
    ref_mul(a, b, r, o, u);
    run_op(a, b, r, o, u, tag);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 10));
      3:       e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(90, 165));
    endcase
    f = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  typedef struct {
    logic [31:0] a, b, r;
    logic        o, u;
  } vec_t;

  vec_t dir[10] = '{
    '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0},
    '{32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0, 1'b0},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0},
    '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0},
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0}
  };

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset result", result, 32'd0);
    check("reset ctrl", {28'd0, overflow, underflow, enable, busy}, 32'd0);

    foreach (dir[i])
      run_op(dir[i].a, dir[i].b, dir[i].r, dir[i].o, dir[i].u, $sformatf("dir%0d", i));

    // start held high: one enable every 27 cycles, result held between
    @(negedge CLK);
    A = 32'h40000000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge CLK); #1;
    for (int c = 1; c <= 80; c++) begin
      check($sformatf("hold en c%0d", c), {31'd0, enable}, {31'd0, (c % 27) == 26});
      if (c < 26)
        check($sformatf("hold prev c%0d", c), result, 32'h80000000);
      if (c == 80) start = 1'b0;
      @(posedge CLK); #1;
    end
    check("hold result", result, 32'h40C00000);

    // mid-operation reset
    @(negedge CLK);
    A = 32'h3FC00000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort result", result, 32'd0);
    check("abort ctrl", {28'd0, overflow, underflow, enable, busy}, 32'd0);
    run_op(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, "post-rst");

    for (int i = 0; i < 150; i++)
      run_ref(rand_operand(), rand_operand(), $sformatf("rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
